rx_addr_filter_ctrl: RTL and testbench
======================================

Name: rx_addr_filter_ctrl

Overview:
Sequences destination-address filtering for the simple_gemac RX path. Tracks frame framing on the post-SFD byte stream and walks the first six bytes, the destination MAC, against one programmable unicast address plus broadcast, multicast and promiscuous policy. Issues one registered accept/drop verdict per frame to the RX FIFO write controller. Sits between the GMII RX deframer and the RX FIFO.

Parameters:
DEFAULT_MAC, 48'h000000000000, reset value of the internal unicast address register.
DEFAULT_FLAGS, 3'b000, reset value of {promisc, pass_bcast, pass_mcast}.

Ports:
clk  in  1  clock
reset  in  1  reset
cfg_we  in  1  write strobe for the config registers
cfg_mac  in  48  unicast MAC; byte0 = [47:40], byte5 = [7:0]
cfg_flags  in  3  {promisc, pass_bcast, pass_mcast}
rx_valid  in  1  byte strobe; all rx_* qualifiers are sampled only when high
rx_data  in  8  frame byte
rx_sof  in  1  marks the first byte after SFD (dest byte0)
rx_eof  in  1  marks the last byte of the frame
rx_error  in  1  PHY error on this byte
verdict_valid  out  1  single-cycle verdict pulse
verdict_accept  out  1  1 = keep frame, 0 = drop
verdict_kind  out  2  0 ucast match, 1 bcast, 2 mcast, 3 other/runt/error
busy  out  1  high while not IDLE

Behaviour:
- reset is synchronous and active-high on clk. On reset: state=IDLE, byte_idx=0, mac_reg=DEFAULT_MAC, flags=DEFAULT_FLAGS, verdict_valid=0, verdict_accept=0, verdict_kind=0, busy=0.
- Config: cfg_we=1 loads mac_reg and flags. A frame uses a snapshot of both taken at its rx_sof byte, so a mid-frame write does not affect the frame in flight.
- FSM states:
  - IDLE: wait for rx_valid & rx_sof.
  - ADDR: evaluating bytes 0..5.
  - WAIT_EOF: verdict issued, wait for end of frame.
- IDLE -> ADDR on rx_valid & rx_sof. That byte is byte 0 and is evaluated in the same cycle.
- ADDR running flags, initialised at byte 0:
  - uc_ok &= (rx_data == snapshot byte[byte_idx])
  - bc_ok &= (rx_data == 8'hFF)
  - mc = byte0 bit0
  - err |= rx_error
- byte_idx advances only on rx_valid. Idle cycles (rx_valid=0) inside the address field are legal and hold all state.
- Verdict on the byte_idx=5 byte:
  - Kind priority: err -> 3; bc_ok -> 1; uc_ok -> 0; mc -> 2; else 3.
  - accept = !err & (promisc | uc_ok | (bc_ok & pass_bcast) | (mc & !bc_ok & pass_mcast)).
- Latency: verdict_valid pulses exactly one clk after the edge that samples byte 5, for one cycle. verdict_accept and verdict_kind stay valid until the next pulse.
- After byte 5: rx_eof on that same byte -> IDLE; otherwise -> WAIT_EOF.
- Runt: rx_eof on any byte with idx<5 -> verdict pulse next cycle with accept=0, kind=3, even if promisc is set; state -> IDLE. rx_sof & rx_eof on the same byte is a 1-byte runt.
- rx_sof while in ADDR (aborted frame): a runt verdict is issued for the old frame and byte 0 of the new frame is evaluated in the same cycle. State stays ADDR, byte_idx -> 1.
- rx_sof while in WAIT_EOF: no verdict. Treated as the start of a new frame -> ADDR.
- WAIT_EOF -> IDLE on rx_valid & rx_eof. rx_error in WAIT_EOF is ignored; downstream CRC/error logic owns it.
- busy = (state != IDLE).
- reset mid-frame aborts with no verdict. The next frame is processed only from its next rx_sof.

Optional Feature:
Macro RX_ADDR_FILTER_STATS_EN. When defined, adds:
- outputs stat_accept[15:0] and stat_drop[15:0]
- input stat_clr (1 bit)

Each verdict_valid increments the matching counter. Counters saturate at 16'hFFFF and are cleared by reset or stat_clr; stat_clr wins over a same-cycle increment. When undefined, these ports and counters do not exist and the remaining behaviour is unchanged.

Test Plan:
1. cfg_mac=48'h00_0A_35_01_02_03, flags=000, frame dest 00:0A:35:01:02:03 with 64 bytes -> one pulse, accept=1, kind=0, one cycle after byte 5; busy falls the cycle after eof.
2. Dest FF:FF:FF:FF:FF:FF with pass_bcast=0, then with pass_bcast=1 -> accept=0/kind=1, then accept=1/kind=1. Dest 01:00:5E:00:00:01 with pass_mcast=1 -> accept=1, kind=2.
3. Promisc=1, dest 12:34:56:78:9A:BC -> accept=1, kind=3. Same frame with rx_error on byte 2 -> accept=0, kind=3.
4. Runt: rx_eof on byte 3 with promisc=1 -> pulse with accept=0, kind=3, state IDLE. rx_sof & rx_eof on a single byte -> same result.
5. rx_valid gaps of 0-3 cycles between address bytes, plus cfg_we writing a new MAC at byte 2 -> verdict uses the old MAC, timing still one cycle after byte 5. rx_sof at byte 4 -> runt pulse, then a correct verdict for the new frame.
6. reset asserted at byte 3 -> no pulse, all outputs 0. With RX_ADDR_FILTER_STATS_EN: 3 accepts and 2 drops -> stat_accept=3, stat_drop=2; stat_clr -> 0; forced 16'hFFFF + accept stays 16'hFFFF.

Source files
------------

// File: rtl/rx_addr_filter_ctrl.sv
// rtl/rx_addr_filter_ctrl.sv - RX destination-address filter sequencer (optional stats: RX_ADDR_FILTER_STATS_EN)
module rx_addr_filter_ctrl #(
   parameter logic [47:0] DEFAULT_MAC   = 48'h000000000000,
   parameter logic [2:0]  DEFAULT_FLAGS = 3'b000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_we,
   input  logic [47:0] cfg_mac,
   input  logic [2:0]  cfg_flags,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        rx_sof,
   input  logic        rx_eof,
   input  logic        rx_error,
`ifdef RX_ADDR_FILTER_STATS_EN
   input  logic        stat_clr,
   output logic [15:0] stat_accept,
   output logic [15:0] stat_drop,
`endif
   output logic        verdict_valid,
   output logic        verdict_accept,
   output logic [1:0]  verdict_kind,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ADDR, WAIT_EOF} state_t;

   state_t      state;
   logic [2:0]  byte_idx;
   logic [47:0] mac_reg;
   logic [2:0]  flags_reg;
   logic [47:0] snap_mac;
   logic [2:0]  snap_flags;
   logic        uc_ok;
   logic        bc_ok;
   logic        mc;
   logic        err;

   // a new frame may start in any state; its byte 0 is judged against the live config,
   // later bytes against the snapshot taken on that same byte
   logic        start;
   logic        cont;
   logic        eval;
   logic        abort;
   logic        last;
   logic        runt;
   logic [2:0]  eff_idx;
   logic [47:0] use_mac;
   logic [7:0]  exp_byte;
   logic        n_uc;
   logic        n_bc;
   logic        n_mc;
   logic        n_err;
   logic        full_accept;
   logic [1:0]  full_kind;

   assign start   = rx_valid & rx_sof;
   assign cont    = rx_valid & ~rx_sof & (state == ADDR);
   assign eval    = start | cont;
   assign abort   = start & (state == ADDR);
   assign eff_idx = start ? 3'd0 : byte_idx;
   assign use_mac = start ? mac_reg : snap_mac;
   assign last    = eval & (eff_idx == 3'd5);
   assign runt    = eval & rx_eof & (eff_idx != 3'd5);

   // pick the expected unicast byte for the current address position
   always_comb begin
      exp_byte = use_mac[47:40];
      case (eff_idx)
         3'd0:    exp_byte = use_mac[47:40];
         3'd1:    exp_byte = use_mac[39:32];
         3'd2:    exp_byte = use_mac[31:24];
         3'd3:    exp_byte = use_mac[23:16];
         3'd4:    exp_byte = use_mac[15:8];
         3'd5:    exp_byte = use_mac[7:0];
         default: exp_byte = use_mac[47:40];
      endcase
   end

   assign n_uc  = (start | uc_ok) & (rx_data == exp_byte);
   assign n_bc  = (start | bc_ok) & (rx_data == 8'hFF);
   assign n_mc  = start ? rx_data[0] : mc;
   assign n_err = (~start & err) | rx_error;

   // verdict for a frame whose sixth address byte is on the bus this cycle
   always_comb begin
      full_accept = ~n_err & (snap_flags[2] | n_uc | (n_bc & snap_flags[1]) |
                              (n_mc & ~n_bc & snap_flags[0]));
      if (n_err)     full_kind = 2'd3;
      else if (n_bc) full_kind = 2'd1;
      else if (n_uc) full_kind = 2'd0;
      else if (n_mc) full_kind = 2'd2;
      else           full_kind = 2'd3;
   end

   // framing FSM, config registers, address walk and registered verdict
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         byte_idx       <= 3'd0;
         mac_reg        <= DEFAULT_MAC;
         flags_reg      <= DEFAULT_FLAGS;
         snap_mac       <= DEFAULT_MAC;
         snap_flags     <= DEFAULT_FLAGS;
         uc_ok          <= 1'b0;
         bc_ok          <= 1'b0;
         mc             <= 1'b0;
         err            <= 1'b0;
         verdict_valid  <= 1'b0;
         verdict_accept <= 1'b0;
         verdict_kind   <= 2'd0;
      end else begin
         if (cfg_we) begin
            mac_reg   <= cfg_mac;
            flags_reg <= cfg_flags;
         end

         verdict_valid <= 1'b0;
         if (last) begin
            verdict_valid  <= 1'b1;
            verdict_accept <= full_accept;
            verdict_kind   <= full_kind;
         end else if (abort | runt) begin
            verdict_valid  <= 1'b1;
            verdict_accept <= 1'b0;
            verdict_kind   <= 2'd3;
         end

         if (start) begin
            snap_mac   <= mac_reg;
            snap_flags <= flags_reg;
         end

         if (eval) begin
            uc_ok <= n_uc;
            bc_ok <= n_bc;
            mc    <= n_mc;
            err   <= n_err;
            if (last) begin
               state    <= rx_eof ? IDLE : WAIT_EOF;
               byte_idx <= 3'd0;
            end else if (rx_eof) begin
               state    <= IDLE;
               byte_idx <= 3'd0;
            end else begin
               state    <= ADDR;
               byte_idx <= eff_idx + 3'd1;
            end
         end else if ((state == WAIT_EOF) && rx_valid && rx_eof) begin
            state <= IDLE;
         end
      end
   end

   assign busy = (state != IDLE);

`ifdef RX_ADDR_FILTER_STATS_EN
   // saturating per-verdict counters; clear beats a same-cycle increment
   always_ff @(posedge clk) begin
      if (reset || stat_clr) begin
         stat_accept <= 16'd0;
         stat_drop   <= 16'd0;
      end else if (verdict_valid) begin
         if (verdict_accept) begin
            if (stat_accept != 16'hFFFF) stat_accept <= stat_accept + 16'd1;
         end else begin
            if (stat_drop != 16'hFFFF) stat_drop <= stat_drop + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_rx_addr_filter_ctrl.sv
// tb/tb_rx_addr_filter_ctrl.sv - self-checking bench for rx_addr_filter_ctrl
module tb_rx_addr_filter_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_we = 1'b0;
   logic [47:0] cfg_mac = 48'h0;
   logic [2:0]  cfg_flags = 3'b000;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_sof = 1'b0;
   logic        rx_eof = 1'b0;
   logic        rx_error = 1'b0;
   logic        verdict_valid;
   logic        verdict_accept;
   logic [1:0]  verdict_kind;
   logic        busy;
`ifdef RX_ADDR_FILTER_STATS_EN
   logic        stat_clr = 1'b0;
   logic [15:0] stat_accept;
   logic [15:0] stat_drop;
`endif

   rx_addr_filter_ctrl dut (
      .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_mac(cfg_mac), .cfg_flags(cfg_flags),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof), .rx_eof(rx_eof),
      .rx_error(rx_error),
`ifdef RX_ADDR_FILTER_STATS_EN
      .stat_clr(stat_clr), .stat_accept(stat_accept), .stat_drop(stat_drop),
`endif
      .verdict_valid(verdict_valid), .verdict_accept(verdict_accept),
      .verdict_kind(verdict_kind), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // reference model state: frame-level view (collected address bytes), not an FSM copy
   logic [47:0] mac_m;
   logic [2:0]  flags_m;
   logic [7:0]  q[$];
   logic [47:0] snap_m;
   logic [2:0]  snapf_m;
   bit          in_addr;
   bit          in_body;
   bit          err_m;
   logic        exp_acc;
   logic [1:0]  exp_kind;
   int          acc_cnt;
   int          drop_cnt;
   bit          prev_vv;
   logic        prev_acc;

   logic [7:0]  dest [6];
   logic [47:0] new_mac;
   logic [2:0]  new_flags;

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
   endtask

   task automatic model_clear();
      mac_m = 48'h0; flags_m = 3'b000; q.delete(); in_addr = 0; in_body = 0; err_m = 0;
      exp_acc = 1'b0; exp_kind = 2'd0; acc_cnt = 0; drop_cnt = 0; prev_vv = 0; prev_acc = 1'b0;
   endtask

   task automatic set_dest(input logic [47:0] m);
      for (int i = 0; i < 6; i++) dest[i] = m[47-8*i -: 8];
   endtask

   // judge a complete six-byte destination against the frame's snapshot config
   task automatic judge(output logic acc, output logic [1:0] kind);
      bit uc, bc, mcb;
      uc = 1; bc = 1;
      for (int i = 0; i < 6; i++) begin
         if (q[i] != snap_m[47-8*i -: 8]) uc = 0;
         if (q[i] != 8'hFF) bc = 0;
      end
      mcb = q[0][0];
      kind = err_m ? 2'd3 : bc ? 2'd1 : uc ? 2'd0 : mcb ? 2'd2 : 2'd3;
      acc = !err_m && (snapf_m[2] || uc || (bc && snapf_m[1]) || (mcb && !bc && snapf_m[0]));
   endtask

   task automatic step(input logic v, input logic [7:0] d, input logic s, input logic e,
                       input logic er);
      bit       evv;
      logic     ea;
      logic [1:0] ek;
      rx_valid = v; rx_data = d; rx_sof = s; rx_eof = e; rx_error = er;
      evv = 0; ea = 1'b0; ek = 2'd3;
`ifdef RX_ADDR_FILTER_STATS_EN
      if (stat_clr) begin acc_cnt = 0; drop_cnt = 0; end
      else if (prev_vv) begin
         if (prev_acc) acc_cnt = (acc_cnt < 65535) ? acc_cnt + 1 : acc_cnt;
         else drop_cnt = (drop_cnt < 65535) ? drop_cnt + 1 : drop_cnt;
      end
`endif
      if (v) begin
         if (s) begin
            if (in_addr) evv = 1;
            q.delete(); q.push_back(d);
            snap_m = mac_m; snapf_m = flags_m; err_m = er; in_addr = 1; in_body = 0;
         end else if (in_addr) begin
            q.push_back(d); err_m = err_m | er;
         end else if (in_body && e) begin
            in_body = 0;
         end
         if (in_addr) begin
            if (q.size() == 6) begin
               evv = 1; judge(ea, ek); in_addr = 0; in_body = !e;
            end else if (e) begin
               evv = 1; ea = 1'b0; ek = 2'd3; in_addr = 0;
            end
         end
      end
      if (cfg_we) begin mac_m = cfg_mac; flags_m = cfg_flags; end
      @(posedge clk); #1;
      if (evv) begin exp_acc = ea; exp_kind = ek; end
      prev_vv = evv; prev_acc = ea;
      chk("verdict_valid", 16'(verdict_valid), 16'(evv));
      chk("verdict_accept", 16'(verdict_accept), 16'(exp_acc));
      chk("verdict_kind", 16'(verdict_kind), 16'(exp_kind));
      chk("busy", 16'(busy), 16'(in_addr || in_body));
`ifdef RX_ADDR_FILTER_STATS_EN
      chk("stat_accept", stat_accept, 16'(acc_cnt));
      chk("stat_drop", stat_drop, 16'(drop_cnt));
`endif
   endtask

   task automatic idle();
      step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic do_cfg(input logic [47:0] m, input logic [2:0] f);
      cfg_we = 1'b1; cfg_mac = m; cfg_flags = f;
      idle();
      cfg_we = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; rx_valid = 1'b0; cfg_we = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_clear();
      chk("rst_verdict_valid", 16'(verdict_valid), 16'd0);
      chk("rst_verdict_accept", 16'(verdict_accept), 16'd0);
      chk("rst_verdict_kind", 16'(verdict_kind), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
`ifdef RX_ADDR_FILTER_STATS_EN
      chk("rst_stat_accept", stat_accept, 16'd0);
      chk("rst_stat_drop", stat_drop, 16'd0);
`endif
   endtask

   task automatic send_frame(input int len, input int maxgap, input int err_at,
                             input bit with_eof, input int cfg_at);
      for (int i = 0; i < len; i++) begin
         if (i > 0) repeat ($urandom_range(maxgap, 0)) idle();
         cfg_we = (i == cfg_at);
         if (i == cfg_at) begin cfg_mac = new_mac; cfg_flags = new_flags; end
         step(1'b1, (i < 6) ? dest[i] : 8'($urandom), i == 0, with_eof && (i == len - 1),
              i == err_at);
         cfg_we = 1'b0;
      end
   endtask

   initial begin
      logic [47:0] pool [4];
      pool[0] = 48'h000A35010203; pool[1] = 48'hFFFFFFFFFFFF;
      pool[2] = 48'h01005E000001; pool[3] = 48'h123456789ABC;
      model_clear();
      new_mac = 48'h0; new_flags = 3'b000;
      do_reset();

      do_cfg(48'h000A35010203, 3'b000);
      set_dest(48'h000A35010203);
      send_frame(64, 0, -1, 1, -1);
      idle();
      chk("t1_idle_after_eof", 16'(busy), 16'd0);

      set_dest(48'hFFFFFFFFFFFF);
      send_frame(20, 0, -1, 1, -1);
      do_cfg(48'h000A35010203, 3'b010);
      send_frame(20, 1, -1, 1, -1);
      do_cfg(48'h000A35010203, 3'b001);
      set_dest(48'h01005E000001);
      send_frame(20, 0, -1, 1, -1);

      do_cfg(48'h000A35010203, 3'b100);
      set_dest(48'h123456789ABC);
      send_frame(20, 0, -1, 1, -1);
      send_frame(20, 0, 2, 1, -1);

      set_dest(48'h000A35010203);
      send_frame(4, 0, -1, 1, -1);
      send_frame(1, 0, -1, 1, -1);

      do_cfg(48'h000A35010203, 3'b000);
      new_mac = 48'h665544332211; new_flags = 3'b000;
      send_frame(12, 3, -1, 1, 2);
      send_frame(4, 2, -1, 0, -1);
      set_dest(48'h665544332211);
      send_frame(10, 2, -1, 1, -1);

      send_frame(3, 0, -1, 0, -1);
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0, i == 4, 1'b0);
      send_frame(8, 1, -1, 1, -1);

`ifdef RX_ADDR_FILTER_STATS_EN
      stat_clr = 1'b1; idle(); stat_clr = 1'b0;
`endif

      for (int n = 0; n < 200; n++) begin
         int sel;
         logic [47:0] base;
         if ($urandom_range(3, 0) == 0) do_cfg(pool[$urandom_range(3, 0)], 3'($urandom));
         new_mac = pool[$urandom_range(3, 0)]; new_flags = 3'($urandom);
         base = mac_m;
         sel = $urandom_range(4, 0);
         case (sel)
            0: set_dest(base);
            1: set_dest(48'hFFFFFFFFFFFF);
            2: set_dest({8'($urandom) | 8'h01, 40'($urandom)});
            3: set_dest({16'($urandom), 32'($urandom)});
            default: begin
               base[8*$urandom_range(5, 0) +: 8] ^= 8'h10;
               set_dest(base);
            end
         endcase
         if ($urandom_range(5, 0) == 0) send_frame($urandom_range(5, 1), 2, -1, 0, -1);
         send_frame($urandom_range(9, 1), $urandom_range(3, 0),
                    ($urandom_range(3, 0) == 0) ? $urandom_range(7, 0) : -1, 1,
                    ($urandom_range(2, 0) == 0) ? $urandom_range(6, 0) : -1);
         repeat ($urandom_range(2, 0)) idle();
`ifdef RX_ADDR_FILTER_STATS_EN
         if ($urandom_range(30, 0) == 0) begin stat_clr = 1'b1; idle(); stat_clr = 1'b0; end
`endif
      end

      repeat (3) idle();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
